// File: rtl/serial_subtractor_16_if.sv
// Start/busy/done handshake and operand/result bus of serial_subtractor_16.
// The requester uses the master modport, the subtractor uses the slave modport.
interface serial_subtractor_16_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             ovf;
    logic             zero;

    modport master (
        output start, in1, in2, b_in,
        input  busy, done, diff, b_out, ovf, zero
    );

    modport slave (
        input  start, in1, in2, b_in,
        output busy, done, diff, b_out, ovf, zero
    );
endinterface

// File: rtl/serial_subtractor_16.sv
// Multi-cycle two's-complement subtractor: in1 - in2 - b_in, one SLICE_W-bit
// slice per clock, LSB slice first, with a registered borrow between slices.
module serial_subtractor_16 #(
    parameter int WIDTH   = 16,
    parameter int SLICE_W = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_subtractor_16_if.slave bus
);
    localparam int N     = WIDTH / SLICE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if (!(SLICE_W == 1 || SLICE_W == 2 || SLICE_W == 4 || SLICE_W == 8 || SLICE_W == 16)
        || (WIDTH % SLICE_W) != 0) begin : g_bad_slice
        $error("serial_subtractor_16: SLICE_W=%0d is illegal for WIDTH=%0d", SLICE_W, WIDTH);
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q;
    logic [WIDTH-1:0] res_d;
    logic             a_msb_q, b_msb_q;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] diff_q;
    logic             b_out_q, ovf_q, zero_q;
    logic [SLICE_W:0] slice_full;

    // The extra top bit of the slice subtraction is the borrow into the next slice.
    // Result slices enter from the top and shift down, so after N slices slice 0
    // sits at the LSB.
    always_comb begin
        slice_full = {1'b0, a_sh_q[SLICE_W-1:0]} - {1'b0, b_sh_q[SLICE_W-1:0]}
                   - (SLICE_W + 1)'(borrow_q);
        res_d      = (res_sh_q >> SLICE_W)
                   | (WIDTH'(slice_full[SLICE_W-1:0]) << (WIDTH - SLICE_W));
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (cnt_q == LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            b_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else if (state_q == S_IDLE && bus.start) begin
            a_sh_q   <= bus.in1;
            b_sh_q   <= bus.in2;
            a_msb_q  <= bus.in1[WIDTH-1];
            b_msb_q  <= bus.in2[WIDTH-1];
            borrow_q <= bus.b_in;
            cnt_q    <= '0;
        end else if (state_q == S_RUN) begin
            a_sh_q   <= a_sh_q >> SLICE_W;
            b_sh_q   <= b_sh_q >> SLICE_W;
            res_sh_q <= res_d;
            borrow_q <= slice_full[SLICE_W];
            cnt_q    <= cnt_q + 1'b1;
            // Visible results only move on the final slice; flags use the full result.
            if (cnt_q == LAST) begin
                diff_q  <= res_d;
                b_out_q <= slice_full[SLICE_W];
                ovf_q   <= (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
                zero_q  <= (res_d == '0);
            end
        end
    end

    assign bus.busy  = (state_q == S_RUN);
    assign bus.done  = (state_q == S_DONE);
    assign bus.diff  = diff_q;
    assign bus.b_out = b_out_q;
    assign bus.ovf   = ovf_q;
    assign bus.zero  = zero_q;
endmodule

// File: tb/tb_serial_subtractor_16.sv
// Directed and randomised checks of serial_subtractor_16 for SLICE_W = 1, 2, 4, 8, 16.
// Instance g has SLICE_W = 1 << g; directed tests target the default SLICE_W = 4 (g = 2).
module tb_serial_subtractor_16;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        b_in = 1'b0;
    logic [15:0] in1 = '0;
    logic [15:0] in2 = '0;
    logic [4:0]  en = '0;

    logic [4:0]  busy_v, done_v, bout_v, ovf_v, zero_v;
    logic [15:0] diff_v [5];

    int lat [5];
    int dcnt [5];
    int bcnt [5];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        serial_subtractor_16_if #(.WIDTH(16)) bus ();

        assign bus.start  = start & en[g];
        assign bus.in1    = in1;
        assign bus.in2    = in2;
        assign bus.b_in   = b_in;
        assign busy_v[g]  = bus.busy;
        assign done_v[g]  = bus.done;
        assign diff_v[g]  = bus.diff;
        assign bout_v[g]  = bus.b_out;
        assign ovf_v[g]   = bus.ovf;
        assign zero_v[g]  = bus.zero;

        serial_subtractor_16 #(.WIDTH(16), .SLICE_W(1 << g)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    task automatic check(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[sw=%0d]: observed=%0h expected=%0h", tag, 1 << g, obs, exp);
        end
    endtask

    // One operation on the instances selected by m; busy, done and latency are
    // sampled 1 time unit after each edge. A second start is injected at k = ign_at.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                          input logic [4:0] m, input int ign_at);
        for (int g = 0; g < 5; g++) begin
            lat[g] = 0;
            dcnt[g] = 0;
            bcnt[g] = 0;
        end
        @(negedge clk);
        in1 = a; in2 = b; b_in = bi; en = m; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int g = 0; g < 5; g++) if (busy_v[g]) bcnt[g]++;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 5; g++) begin
                if (busy_v[g]) bcnt[g]++;
                if (done_v[g]) begin
                    dcnt[g]++;
                    if (lat[g] == 0) lat[g] = k;
                end
            end
            if (k == ign_at) begin
                in1 = 16'h0000; in2 = 16'hFFFF; b_in = 1'b1; start = 1'b1;
            end
            if (k == ign_at + 1) start = 1'b0;
        end
    endtask

    task automatic check_dir(input string tag, input logic [15:0] ed, input logic eb,
                             input logic eo, input logic ez);
        check({tag, "_latency"}, 2, lat[2], 4);
        check({tag, "_done_pulses"}, 2, dcnt[2], 1);
        check({tag, "_busy_cycles"}, 2, bcnt[2], 4);
        check({tag, "_diff"}, 2, diff_v[2], ed);
        check({tag, "_b_out"}, 2, bout_v[2], eb);
        check({tag, "_ovf"}, 2, ovf_v[2], eo);
        check({tag, "_zero"}, 2, zero_v[2], ez);
    endtask

    // Reference written arithmetically over integers rather than bit slices.
    task automatic check_model(input int g, input logic [15:0] a, input logic [15:0] b, input logic bi);
        int u, s, n;
        logic [15:0] ed;
        u  = int'(a) - int'(b) - int'(bi);
        s  = int'($signed(a)) - int'($signed(b)) - int'(bi);
        ed = 16'(u);
        n  = 16 >> g;
        check("sweep_latency", g, lat[g], n);
        check("sweep_done_pulses", g, dcnt[g], 1);
        check("sweep_busy_cycles", g, bcnt[g], n);
        check("sweep_diff", g, diff_v[g], ed);
        check("sweep_b_out", g, bout_v[g], (u < 0) ? 1 : 0);
        check("sweep_ovf", g, ovf_v[g], (s < -32768 || s > 32767) ? 1 : 0);
        check("sweep_zero", g, zero_v[g], (ed == 16'h0000) ? 1 : 0);
    endtask

    initial begin
        int ab_done;
        logic [15:0] ra, rb;
        logic rbi;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_busy", 2, busy_v[2], 0);
        check("rst_done", 2, done_v[2], 0);
        check("rst_diff", 2, diff_v[2], 0);
        check("rst_flags", 2, {bout_v[2], ovf_v[2], zero_v[2]}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h0234, 1'b0, 5'b00100, -1);
        check_dir("basic", 16'h1000, 1'b0, 1'b0, 1'b0);

        run_op(16'h0000, 16'h0001, 1'b0, 5'b00100, -1);
        check_dir("underflow", 16'hFFFF, 1'b1, 1'b0, 1'b0);

        run_op(16'h8000, 16'h0001, 1'b0, 5'b00100, -1);
        check_dir("ovf_neg", 16'h7FFF, 1'b0, 1'b1, 1'b0);

        run_op(16'h7FFF, 16'hFFFF, 1'b0, 5'b00100, -1);
        check_dir("ovf_pos", 16'h8000, 1'b1, 1'b1, 1'b0);

        // Abort mid-RUN: outputs must clear immediately and no done pulse follows
        @(negedge clk);
        in1 = 16'h1234; in2 = 16'h0234; b_in = 1'b0; en = 5'b00100; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #3;
        check("abort_busy_before", 2, busy_v[2], 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 2, busy_v[2], 0);
        check("abort_done", 2, done_v[2], 0);
        check("abort_diff", 2, diff_v[2], 0);
        check("abort_b_out", 2, bout_v[2], 0);
        check("abort_ovf", 2, ovf_v[2], 0);
        check("abort_zero", 2, zero_v[2], 0);
        ab_done = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done_v[2]) ab_done++;
        end
        check("abort_no_done", 2, ab_done, 0);

        run_op(16'h5555, 16'h5554, 1'b1, 5'b00100, -1);
        check_dir("bin_zero", 16'h0000, 1'b0, 1'b0, 1'b1);

        // Start pulsed two cycles into RUN must be ignored
        run_op(16'hABCD, 16'h1234, 1'b0, 5'b00100, 2);
        check_dir("ignore_start", 16'h9999, 1'b0, 1'b0, 1'b0);

        // Sweep over every slice width with corner and random operands
        for (int i = 0; i < 1000; i++) begin
            case (i)
                0:       begin ra = 16'h0000; rb = 16'hFFFF; rbi = 1'b1; end
                1:       begin ra = 16'hFFFF; rb = 16'h0000; rbi = 1'b0; end
                2:       begin ra = 16'h8000; rb = 16'h7FFF; rbi = 1'b1; end
                3:       begin ra = 16'h0001; rb = 16'h0000; rbi = 1'b1; end
                default: begin
                    ra  = 16'($urandom);
                    rb  = 16'($urandom);
                    rbi = 1'($urandom_range(1));
                end
            endcase
            run_op(ra, rb, rbi, 5'b11111, -1);
            for (int g = 0; g < 5; g++) check_model(g, ra, rb, rbi);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
